id_ex_forward_register: RTL
===========================

Name: id_ex_forward_register

Overview:
- Consumer end of the hazard/forwarding interface. Receives Data_Forw_PA/PB/PD and NOP from the hazard-forwarding unit.
- Applies the forwarding selects to the three ID-stage operands, then registers operands and control into the ID/EX pipeline register.
- Inserts a bubble when NOP is low or when flush is asserted.
- Tracks stall runs with a small FSM and counters for watchdog and performance visibility.

Parameters:
- DATA_W, 32, operand and result width.
- CTRL_W, 12, width of the ID control bundle passed to EX.
- MAX_STALL, 4, number of consecutive stall cycles that trips the watchdog (must be at least 2).
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- Data_Forw_PA  in  2  operand A select: 00 rf, 01 ex, 10 mem, 11 wb.
- Data_Forw_PB  in  2  operand B select, same encoding as A.
- Data_Forw_PD  in  2  operand D (store data) select, same encoding as A.
- NOP  in  1  1 = pass the instruction; 0 = stall, insert a bubble.
- flush  in  1  1 = squash the ID instruction (taken branch).
- rf_pa, rf_pb, rf_pd  in  DATA_W  register-file read ports.
- ex_result, mem_result, wb_result  in  DATA_W  forwarding sources.
- id_ctrl  in  CTRL_W  decoded control bundle.
- id_rd  in  4  destination register.
- id_rf_enable  in  1  instruction writes the register file.
- id_load_instr  in  1  instruction is a load.
- ex_pa, ex_pb, ex_pd  out  DATA_W  registered operands.
- ex_ctrl  out  CTRL_W  registered control bundle.
- ex_rd  out  4  registered destination register.
- ex_rf_enable  out  1  registered register-file write enable.
- ex_load_instr  out  1  registered load flag.
- stall_state  out  2  FSM state: 00 RUN, 01 STALL, 10 TIMEOUT.
- stall_run  out  8  length of the current consecutive stall run.
- bubble_cnt  out  CNT_W  total bubbles inserted.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, stall_state = RUN. Reset takes effect immediately, including mid-stall or in TIMEOUT.
- Operand muxes (combinational, before the register):
  - sel 00 → rf_*, 01 → ex_result, 10 → mem_result, 11 → wb_result.
  - A, B and D select independently.
- Register update, latency 1 cycle:
  - Capture (NOP = 1 and flush = 0): the selected operands, id_ctrl, id_rd, id_rf_enable and id_load_instr are registered.
  - Bubble (NOP = 0 or flush = 1): ex_ctrl, ex_rd, ex_rf_enable and ex_load_instr are cleared to 0. ex_pa/pb/pd hold their previous values.
  - NOP = 0 together with flush = 1 produces a single bubble, counted once.
- bubble_cnt increments by 1 on every bubble cycle and saturates at all-ones (no wrap).
- Stall FSM, driven by NOP only (flush alone is not a stall):
  - RUN: NOP = 0 → STALL, stall_run = 1. Otherwise stall_run = 0.
  - STALL, NOP = 0: stall_run increments. When the incremented value equals MAX_STALL → TIMEOUT and stall_timeout = 1.
  - STALL, NOP = 1: → RUN, stall_run = 0.
  - TIMEOUT: terminal until reset. stall_timeout stays 1. stall_run keeps counting while NOP = 0, saturates at 255 and clears to 0 when NOP = 1. Register bubbling continues to follow NOP and flush.
- With MAX_STALL = 4, the cycle that registers the 4th consecutive stall sets stall_timeout.
- No internal combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset with all inputs X→0: every output 0, stall_state = 00. Assert reset mid-STALL with stall_run = 2 → outputs 0 immediately, without waiting for a clock edge.
- Selects PA = 01, PB = 10, PD = 11, NOP = 1, ex_result = 0xA, mem_result = 0xB, wb_result = 0xC, id_rd = 5, id_rf_enable = 1 → after 1 edge: ex_pa = 0xA, ex_pb = 0xB, ex_pd = 0xC, ex_rd = 5, ex_rf_enable = 1. Repeat with selects 00 → rf_* values.
- Load-use: id_load_instr = 1 captured, then NOP = 0 for 1 cycle → ex_ctrl/ex_rd/ex_rf_enable/ex_load_instr = 0, ex_pa unchanged, bubble_cnt = 1, stall_state goes 01 then returns to 00, stall_run returns to 0.
- flush = 1 with NOP = 1 → bubble, bubble_cnt +1, stall_state stays 00. flush = 1 with NOP = 0 → bubble_cnt +1 only, stall_state = 01.
- NOP = 0 for 6 cycles, MAX_STALL = 4 → stall_run = 1, 2, 3, 4; stall_timeout rises on the 4th edge; stall_run then reads 5, 6. NOP = 1 → stall_run = 0, stall_timeout stays 1, stall_state = 10.
- Preload bubble_cnt near all-ones with CNT_W = 4, apply 20 bubbles → bubble_cnt = 0xF and holds there (no wrap).

Source files
------------

// File: rtl/id_ex_forward_register.sv
// ID/EX pipeline register with operand forwarding muxes, bubble insertion and a stall watchdog FSM.
// Latency 1 cycle; a stall (NOP low) or flush clears the control fields, operands hold.
module id_ex_forward_register #(
  parameter int DATA_W    = 32,
  parameter int CTRL_W    = 12,
  parameter int MAX_STALL = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        Data_Forw_PA,
  input  logic [1:0]        Data_Forw_PB,
  input  logic [1:0]        Data_Forw_PD,
  input  logic              NOP,
  input  logic              flush,
  input  logic [DATA_W-1:0] rf_pa,
  input  logic [DATA_W-1:0] rf_pb,
  input  logic [DATA_W-1:0] rf_pd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [3:0]        id_rd,
  input  logic              id_rf_enable,
  input  logic              id_load_instr,
  output logic [DATA_W-1:0] ex_pa,
  output logic [DATA_W-1:0] ex_pb,
  output logic [DATA_W-1:0] ex_pd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [3:0]        ex_rd,
  output logic              ex_rf_enable,
  output logic              ex_load_instr,
  output logic [1:0]        stall_state,
  output logic [7:0]        stall_run,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              stall_timeout
);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_STALL   = 2'b01,
    S_TIMEOUT = 2'b10
  } stall_state_t;

  localparam logic [7:0]       MAX_RUN = 8'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf_v,
    input logic [DATA_W-1:0] ex_v,
    input logic [DATA_W-1:0] mem_v,
    input logic [DATA_W-1:0] wb_v
  );
    case (sel)
      2'b00:   return rf_v;
      2'b01:   return ex_v;
      2'b10:   return mem_v;
      default: return wb_v;
    endcase
  endfunction

  logic [DATA_W-1:0] pa_d, pb_d, pd_d;
  logic [DATA_W-1:0] pa_q, pb_q, pd_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [3:0]        rd_q;
  logic              rf_en_q, load_q;
  logic [CNT_W-1:0]  bubble_cnt_q;
  stall_state_t      state_q, state_d;
  logic [7:0]        stall_run_q, stall_run_d;
  logic              timeout_q, timeout_d;
  logic              bubble;

  assign bubble = ~NOP | flush;

  assign pa_d = fwd_sel(Data_Forw_PA, rf_pa, ex_result, mem_result, wb_result);
  assign pb_d = fwd_sel(Data_Forw_PB, rf_pb, ex_result, mem_result, wb_result);
  assign pd_d = fwd_sel(Data_Forw_PD, rf_pd, ex_result, mem_result, wb_result);

  // Operands hold through a bubble; only control is squashed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pa_q         <= '0;
      pb_q         <= '0;
      pd_q         <= '0;
      ctrl_q       <= '0;
      rd_q         <= '0;
      rf_en_q      <= 1'b0;
      load_q       <= 1'b0;
      bubble_cnt_q <= '0;
    end else if (bubble) begin
      ctrl_q  <= '0;
      rd_q    <= '0;
      rf_en_q <= 1'b0;
      load_q  <= 1'b0;
      if (bubble_cnt_q != CNT_MAX) bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end else begin
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      pd_q    <= pd_d;
      ctrl_q  <= id_ctrl;
      rd_q    <= id_rd;
      rf_en_q <= id_rf_enable;
      load_q  <= id_load_instr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      stall_run_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_run_q <= stall_run_d;
      timeout_q   <= timeout_d;
    end
  end

  // Stall tracking looks at NOP only; a flush by itself is not a stall.
  always_comb begin
    state_d     = state_q;
    stall_run_d = stall_run_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_RUN: begin
        if (!NOP) begin
          state_d     = S_STALL;
          stall_run_d = 8'd1;
        end else begin
          stall_run_d = 8'd0;
        end
      end
      S_STALL: begin
        if (!NOP) begin
          stall_run_d = stall_run_q + 8'd1;
          if (stall_run_d == MAX_RUN) begin
            state_d   = S_TIMEOUT;
            timeout_d = 1'b1;
          end
        end else begin
          state_d     = S_RUN;
          stall_run_d = 8'd0;
        end
      end
      S_TIMEOUT: begin
        timeout_d = 1'b1;
        if (!NOP) begin
          if (stall_run_q != 8'hFF) stall_run_d = stall_run_q + 8'd1;
        end else begin
          stall_run_d = 8'd0;
        end
      end
      default: begin
        state_d     = S_RUN;
        stall_run_d = 8'd0;
      end
    endcase
  end

  assign ex_pa         = pa_q;
  assign ex_pb         = pb_q;
  assign ex_pd         = pd_q;
  assign ex_ctrl       = ctrl_q;
  assign ex_rd         = rd_q;
  assign ex_rf_enable  = rf_en_q;
  assign ex_load_instr = load_q;
  assign stall_state   = state_q;
  assign stall_run     = stall_run_q;
  assign bubble_cnt    = bubble_cnt_q;
  assign stall_timeout = timeout_q;

endmodule
